if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage; the decode stage consumes `instruction` and its PC.
- Owns the PC register and issues word fetches to instruction memory over a request/response interface with variable latency.
- Buffers fetched instructions in a small FIFO under valid/ready back-pressure from decode.
- Handles branch/jump redirects, flushing the FIFO and dropping in-flight responses.

---
 rtl/if_fetch_stage.sv | 106 ++++++++++
 tb/tb_if_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches
// and buffers responses in a prefetch FIFO ahead of decode.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state, state_nx;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic          pop, push;

   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready & ~redirect;
   assign push        = (state == WAIT) & imem_rvalid & ~redirect;
   assign free        = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
   assign imem_addr   = fetch_pc;

   // Fetching again in the response cycle needs room for both the arriving word and the new one.
   always_comb begin
      imem_req = 1'b0;
      if (!rst && !redirect) begin
         case (state)
            IDLE:    imem_req = (free >= (AW+1)'(1));
            WAIT:    imem_req = imem_rvalid && (free >= (AW+1)'(2));
            default: imem_req = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (imem_req) state_nx = WAIT;
         WAIT: begin
            if (imem_rvalid)   state_nx = imem_req ? WAIT : IDLE;
            else if (redirect) state_nx = DROP;
         end
         DROP: if (imem_rvalid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state <= state_nx;
         if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (imem_req) begin
               req_pc   <= fetch_pc;
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= req_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

   assign instruction = instr_valid ? fifo_instr[rd_ptr] : NOP;
   assign pc_out      = instr_valid ? fifo_pc[rd_ptr] : '0;
   assign pc_plus4    = instr_valid ? fifo_pc[rd_ptr] + 32'd4 : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory model plus an in-order
// stream scoreboard of fetch addresses and delivered instructions.
module tb_if_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .pc_out(pc_out), .pc_plus4(pc_plus4)
   );

   int checks = 0;
   int errors = 0;

   // memory model: one pending request answered lat cycles after it was issued
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat;

   // expected next fetch address and next delivered PC
   logic [31:0] exp_fetch, exp_pc;

   bit          tb_ready, tb_redirect, tb_stray;
   logic [31:0] tb_rpc;

   logic        obs_req, obs_valid;
   logic [31:0] obs_addr, obs_instr, obs_pc, obs_pc4;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit          rv, s_pop;
      logic [31:0] tgt;
      @(negedge clk);
      rv          = mem_busy && (mem_cnt == 1);
      instr_ready = tb_ready;
      redirect    = tb_redirect;
      redirect_pc = tb_rpc;
      if (rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_addr);
      end else if (tb_stray) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      obs_req   = imem_req;
      obs_addr  = imem_addr;
      obs_valid = instr_valid;
      obs_instr = instruction;
      obs_pc    = pc_out;
      obs_pc4   = pc_plus4;
      s_pop     = obs_valid && tb_ready && !tb_redirect;
      if (tb_redirect) chk("no_req_on_redirect", 32'(obs_req), 32'd0);
      if (obs_req) begin
         chk("fetch_addr", obs_addr, exp_fetch);
         chk("single_outstanding", 32'(mem_busy && !rv), 32'd0);
      end
      if (!obs_valid) begin
         chk("empty_instruction", obs_instr, NOP);
         chk("empty_pc_out", obs_pc, 32'd0);
         chk("empty_pc_plus4", obs_pc4, 32'd0);
      end
      if (s_pop) begin
         chk("deliver_pc", obs_pc, exp_pc);
         chk("deliver_instr", obs_instr, mem_word(exp_pc));
         chk("deliver_pc_plus4", obs_pc4, exp_pc + 32'd4);
      end
      @(posedge clk);
      if (s_pop) exp_pc += 32'd4;
      if (tb_redirect) begin
         tgt       = tb_rpc & 32'hFFFF_FFFC;
         exp_pc    = tgt;
         exp_fetch = tgt;
      end
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (obs_req) begin
         mem_busy  = 1'b1;
         mem_cnt   = lat;
         mem_addr  = obs_addr;
         exp_fetch += 32'd4;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      tb_redirect = 1'b0;
      tb_stray    = 1'b0;
      #1;
      chk("reset_imem_req", 32'(imem_req), 32'd0);
      chk("reset_instr_valid", 32'(instr_valid), 32'd0);
      chk("reset_instruction", instruction, NOP);
      chk("reset_pc_out", pc_out, 32'd0);
      chk("reset_pc_plus4", pc_plus4, 32'd0);
      mem_busy  = 1'b0;
      mem_cnt   = 0;
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      int nreq, nvalid, gaps, n;
      bit found;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_rvalid = 1'b0;
      imem_rdata = '0; instr_ready = 1'b0;
      tb_ready = 1'b1; tb_redirect = 1'b0; tb_stray = 1'b0; tb_rpc = '0; lat = 1;

      // streaming at one instruction per cycle with 1-cycle memory
      do_reset();
      tb_ready = 1'b1; lat = 1;
      cycle();
      chk("first_cycle_req", 32'(obs_req), 32'd1);
      chk("first_cycle_valid", 32'(obs_valid), 32'd0);
      cycle();
      chk("latency_valid_low", 32'(obs_valid), 32'd0);
      cycle();
      chk("first_valid", 32'(obs_valid), 32'd1);
      chk("first_pc", obs_pc, 32'h0);
      chk("first_instr", obs_instr, mem_word(32'h0));
      chk("first_pc_plus4", obs_pc4, 32'h4);
      nreq = 0; nvalid = 0;
      repeat (20) begin
         cycle();
         nreq   += int'(obs_req);
         nvalid += int'(obs_valid);
      end
      chk("throughput_valid", 32'(nvalid), 32'd20);
      chk("throughput_req", 32'(nreq), 32'd20);

      // decode stalled from reset: FIFO fills with exactly DEPTH entries
      do_reset();
      tb_ready = 1'b0; lat = 1; nreq = 0;
      repeat (10) begin
         cycle();
         nreq += int'(obs_req);
      end
      chk("stall_req_count", 32'(nreq), 32'd2);
      chk("stall_req_low", 32'(obs_req), 32'd0);
      chk("stall_head_pc", obs_pc, 32'h0);
      chk("stall_fetch_pc", exp_fetch, 32'h8);
      tb_ready = 1'b1; gaps = 0;
      repeat (12) begin
         cycle();
         if (!obs_valid) gaps++;
      end
      chk("release_gaps", 32'(gaps), 32'd0);

      // redirect while the request to 0x8 is outstanding on 3-cycle memory
      do_reset();
      tb_ready = 1'b1; lat = 3; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (obs_req && obs_addr == 32'h8) found = 1'b1;
      end
      chk("saw_req_0x8", 32'(found), 32'd1);
      tb_redirect = 1'b1; tb_rpc = 32'h100;
      cycle();
      tb_redirect = 1'b0;
      cycle();
      chk("flush_empty", 32'(obs_valid), 32'd0);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!obs_req && n < 20);
      chk("drop_then_req_delay", 32'(n), 32'd2);
      chk("redirect_target_addr", obs_addr, 32'h100);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!obs_valid && n < 20);
      chk("redirect_first_pc", obs_pc, 32'h100);

      // redirect coinciding with a response, unaligned target
      n = 0;
      while (!(mem_busy && mem_cnt == 1) && n < 20) begin
         cycle();
         n++;
      end
      chk("found_rvalid_cycle", 32'(mem_busy && mem_cnt == 1), 32'd1);
      tb_redirect = 1'b1; tb_rpc = 32'h103;
      cycle();
      tb_redirect = 1'b0;
      cycle();
      chk("req_after_rvalid_redirect", 32'(obs_req), 32'd1);
      chk("unaligned_target", obs_addr, 32'h100);

      // PC wrap past 0xFFFF_FFFC
      lat = 1;
      tb_redirect = 1'b1; tb_rpc = 32'hFFFF_FFF8;
      cycle();
      tb_redirect = 1'b0; found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (obs_valid && obs_pc == 32'hFFFF_FFFC) found = 1'b1;
      end
      chk("saw_wrap_pc", 32'(found), 32'd1);
      chk("wrap_pc_plus4", obs_pc4, 32'h0);

      // asynchronous reset while a fetch is outstanding, then a stray response
      do_reset();
      tb_ready = 1'b0; lat = 3; n = 0;
      while (!(mem_busy && obs_valid) && n < 30) begin
         cycle();
         n++;
      end
      #2;
      chk("pre_reset_valid", 32'(instr_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_imem_req", 32'(imem_req), 32'd0);
      chk("async_instr_valid", 32'(instr_valid), 32'd0);
      chk("async_instruction", instruction, NOP);
      chk("async_pc_out", pc_out, 32'd0);
      chk("async_pc_plus4", pc_plus4, 32'd0);
      mem_busy = 1'b0; mem_cnt = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      tb_ready = 1'b1; lat = 1; tb_stray = 1'b1;
      cycle();
      tb_stray = 1'b0; n = 0;
      do begin
         cycle();
         n++;
      end while (!obs_valid && n < 20);
      chk("restart_pc", obs_pc, RESET_PC);
      chk("restart_instr", obs_instr, mem_word(RESET_PC));

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         tb_ready    = ($urandom_range(0, 3) != 0);
         lat         = int'($urandom_range(1, 4));
         tb_redirect = ($urandom_range(0, 29) == 0);
         tb_rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
         tb_stray    = !mem_busy && ($urandom_range(0, 15) == 0);
         cycle();
      end
      tb_redirect = 1'b0; tb_stray = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
